// File: rtl/dot_scan_ctrl_if.sv
// Dot coordinate ROM port: the controller drives the address, and the ROM returns
// the coordinates one cycle later.
interface dot_scan_ctrl_if #(
    parameter int IDX_W = 5
);
    logic [IDX_W-1:0] rom_addr;
    logic [9:0]       rom_x;
    logic [9:0]       rom_y;

    modport master (output rom_addr, input rom_x, input rom_y);
    modport slave  (input rom_addr, output rom_x, output rom_y);
endinterface

// File: rtl/dot_scan_ctrl.sv
// Frame-driven dot field scanner: tracks the eaten bitmap, dots_left, score and level clear.
// Optional power pellets (frightened timer) are enabled by defining POWER_PELLET_EN.
//
// state   | meaning
// IDLE    | waiting for frame_start
// SCAN    | issuing ROM addresses 0..NUM_DOTS-1
// DRAIN   | comparing the final ROM entry
// DONE    | scan_done pulse, then go to CLEARED or IDLE
// CLEARED | every dot eaten, held until level_restart
module dot_scan_ctrl #(
    parameter int                  NUM_DOTS      = 32,
    parameter int                  IDX_W         = 5,
    parameter int                  HIT_RADIUS    = 4,
    parameter int                  DOT_POINTS    = 10,
    parameter logic [NUM_DOTS-1:0] PELLET_MASK   = '0,
    parameter int                  FRIGHT_FRAMES = 300
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_start,
    input  logic [9:0]            pX,
    input  logic [9:0]            pY,
    input  logic                  level_restart,
    dot_scan_ctrl_if.master       rom,
    output logic [NUM_DOTS-1:0]   dots_eaten,
    output logic [IDX_W:0]        dots_left,
    output logic [15:0]           score,
    output logic                  busy,
    output logic                  dot_eat,
    output logic                  scan_done,
    output logic                  level_clear,
    output logic                  frightened
);

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, DONE, CLEARED} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOTS - 1);
    localparam logic [IDX_W:0]   LEFT_INIT = (IDX_W + 1)'(NUM_DOTS);
    localparam logic [10:0]      RADIUS    = 11'(HIT_RADIUS);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cmp_idx;
    logic             cmp_valid;
    logic [9:0]       px_lat, py_lat;
    logic [10:0]      dx, dy;
    logic             near;
    logic             eat;
    logic [15:0]      pts;
    logic [16:0]      score_sum;
    logic [15:0]      score_nxt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (level_restart) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (frame_start) state_nxt = SCAN;
                SCAN:    if (idx == LAST_IDX) state_nxt = DRAIN;
                DRAIN:   state_nxt = DONE;
                DONE:    state_nxt = (dots_left == '0) ? CLEARED : IDLE;
                CLEARED: state_nxt = CLEARED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = 1'b0;
        scan_done   = 1'b0;
        level_clear = 1'b0;
        case (state)
            SCAN, DRAIN: busy = 1'b1;
            DONE: begin
                busy      = 1'b1;
                scan_done = 1'b1;
            end
            CLEARED: level_clear = 1'b1;
            default: ;
        endcase
    end

    // idx rests at 0 outside SCAN, so the ROM address is simply the scan index
    assign rom.rom_addr = idx;

    // Unsigned 11-bit absolute differences against the coordinates latched at frame_start
    always_comb begin
        dx   = ({1'b0, px_lat} >= {1'b0, rom.rom_x}) ? ({1'b0, px_lat} - {1'b0, rom.rom_x})
                                                     : ({1'b0, rom.rom_x} - {1'b0, px_lat});
        dy   = ({1'b0, py_lat} >= {1'b0, rom.rom_y}) ? ({1'b0, py_lat} - {1'b0, rom.rom_y})
                                                     : ({1'b0, rom.rom_y} - {1'b0, py_lat});
        near = (dx <= RADIUS) && (dy <= RADIUS);
        eat  = cmp_valid && near && !dots_eaten[cmp_idx] && !level_restart;
    end

`ifdef POWER_PELLET_EN
    localparam int              FR_W      = $clog2(FRIGHT_FRAMES + 1);
    localparam logic [FR_W-1:0] FR_RELOAD = FR_W'(FRIGHT_FRAMES);

    logic [FR_W-1:0] fright_cnt;

    assign pts = PELLET_MASK[cmp_idx] ? 16'd50 : 16'(DOT_POINTS);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                                  fright_cnt <= '0;
        else if (level_restart)                        fright_cnt <= '0;
        else if (eat && PELLET_MASK[cmp_idx])          fright_cnt <= FR_RELOAD;
        else if (state == DONE && fright_cnt != '0)    fright_cnt <= fright_cnt - 1'b1;
    end

    assign frightened = (fright_cnt != '0);
`else
    localparam logic [NUM_DOTS-1:0] unused_pellet_mask = PELLET_MASK;
    localparam int                  unused_fright      = FRIGHT_FRAMES;

    assign pts        = 16'(DOT_POINTS);
    assign frightened = 1'b0;
`endif

    always_comb begin
        score_sum = {1'b0, score} + {1'b0, pts};
        score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx        <= '0;
            cmp_idx    <= '0;
            cmp_valid  <= 1'b0;
            px_lat     <= '0;
            py_lat     <= '0;
            dots_eaten <= '0;
            dots_left  <= LEFT_INIT;
            score      <= '0;
            dot_eat    <= 1'b0;
        end else begin
            dot_eat <= eat;
            if (level_restart) begin
                idx        <= '0;
                cmp_valid  <= 1'b0;
                dots_eaten <= '0;
                dots_left  <= LEFT_INIT;
            end else begin
                cmp_valid <= (state == SCAN);
                cmp_idx   <= idx;
                if (state == IDLE && frame_start) begin
                    px_lat <= pX;
                    py_lat <= pY;
                    idx    <= '0;
                end else if (state == SCAN) begin
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                if (eat) begin
                    dots_eaten[cmp_idx] <= 1'b1;
                    dots_left           <= dots_left - 1'b1;
                    score               <= score_nxt;
                end
            end
        end
    end

endmodule

// File: doc/dot_scan_ctrl.md
Name: dot_scan_ctrl

Overview:
- Frame-driven controller for the maze dot field.
- On each `frame_start` it scans the dot coordinate ROM one entry per cycle and compares each dot against Pac-Man's latched position.
- It keeps the per-dot eaten bitmap, `dots_left`, the score and level-clear status.
- Sits between the Pac-Man motion logic, the dot coordinate ROM and the VGA/score display logic.

Parameters:
- NUM_DOTS, 32, number of dot entries in the ROM (2..256).
- IDX_W, 5, ROM address width; must satisfy 2**IDX_W >= NUM_DOTS.
- HIT_RADIUS, 4, max per-axis pixel distance counted as a hit.
- DOT_POINTS, 10, score added per newly eaten dot.
- PELLET_MASK, 32'h0, bit i set marks dot i as a power pellet (used only with the optional feature).
- FRIGHT_FRAMES, 300, frightened duration in frames (used only with the optional feature).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse requesting a scan.
- pX  in  10  Pac-Man x; sampled on an accepted frame_start.
- pY  in  10  Pac-Man y; sampled on an accepted frame_start.
- level_restart  in  1  one-cycle pulse: restore all dots.
- rom_addr  out  IDX_W  dot ROM address.
- rom_x  in  10  dot x coordinate; valid one cycle after rom_addr.
- rom_y  in  10  dot y coordinate; valid one cycle after rom_addr.
- dots_eaten  out  NUM_DOTS  bit i = 1 means dot i has been eaten.
- dots_left  out  IDX_W+1  count of uneaten dots.
- score  out  16  accumulated score.
- busy  out  1  high in SCAN/DRAIN/DONE.
- dot_eat  out  1  one-cycle pulse for each newly eaten dot.
- scan_done  out  1  one-cycle pulse at end of scan.
- level_clear  out  1  level-held flag; high while in CLEARED.
- frightened  out  1  power-pellet mode active.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - state=IDLE, rom_addr=0, dots_eaten=0, dots_left=NUM_DOTS, score=0.
  - busy, dot_eat, scan_done, level_clear and frightened all 0.
- FSM states: IDLE, SCAN, DRAIN, DONE, CLEARED.
- IDLE:
  - frame_start=1 latches pX/pY, sets idx=0 and moves to SCAN.
  - frame_start in any other state is ignored.
- SCAN:
  - rom_addr=idx; idx increments each cycle.
  - The compare for address k uses rom_x/rom_y in the following cycle (one-stage pipeline).
  - After issuing idx=NUM_DOTS-1, go to DRAIN.
- DRAIN: compares the final entry, then goes to DONE.
- DONE:
  - scan_done=1 for one cycle.
  - Next state is CLEARED if dots_left==0, else IDLE.
- CLEARED:
  - level_clear=1; frame_start is ignored.
  - level_restart returns to IDLE.
- Latency: frame_start accepted at cycle t gives SCAN at t+1..t+NUM_DOTS, DRAIN at t+NUM_DOTS+1, scan_done at t+NUM_DOTS+2.
- Hit condition:
  - |latched_pX - rom_x| <= HIT_RADIUS AND |latched_pY - rom_y| <= HIT_RADIUS.
  - Differences are computed unsigned at 11 bits with no wrap; no negative coordinates exist.
- On a hit with dots_eaten[k]==0, all in the same cycle:
  - set bit k;
  - decrement dots_left;
  - add DOT_POINTS to score, saturating at 16'hFFFF;
  - pulse dot_eat.
- A hit on an already-eaten dot has no effect.
- Multiple dots may be eaten in one scan.
- level_restart in any state, next cycle:
  - dots_eaten=0, dots_left=NUM_DOTS, state=IDLE;
  - any in-flight scan is aborted with no scan_done;
  - score is preserved.
- level_restart and frame_start in the same cycle: restart wins and frame_start is dropped.
- Mid-scan async reset returns all outputs to their reset values immediately.
- dots_left == popcount(~dots_eaten) holds at all times.

Optional Feature:
- Macro: POWER_PELLET_EN.
- Defined:
  - A newly eaten dot with PELLET_MASK[k]=1 scores 50 instead of DOT_POINTS.
  - It loads a frame counter with FRIGHT_FRAMES.
  - frightened=1 while counter>0.
  - The counter decrements once per scan_done.
  - Another pellet reloads the counter.
  - level_restart clears the counter.
- Undefined: frightened is tied 0 and PELLET_MASK is ignored.

Test Plan:
- Reset, then pX=60,pY=20, one frame_start (ROM row 0: 60/120/180/245/305/365 at y=20) -> dot_eat once; dots_eaten[0]=1, dots_left=31, score=10; scan_done exactly 34 cycles after frame_start.
- Repeat the same position for a second frame -> no dot_eat; score stays 10, dots_left stays 31.
- pX=64,pY=24 (edge of HIT_RADIUS) -> dot 0 eaten; pX=65,pY=20 -> not eaten.
- Eat all 32 dots (ROM entries placed on one coordinate) -> dots_left=0; after scan_done, level_clear=1; further frame_start ignored; level_restart -> dots_left=32, level_clear=0, score retained (320).
- level_restart pulsed mid-scan (cycle 10 of SCAN) -> no scan_done; next cycle busy=0, dots_eaten=0; simultaneous frame_start dropped.
- POWER_PELLET_EN, PELLET_MASK=1, FRIGHT_FRAMES=3, eat dot 0 -> score=50; frightened=1 for exactly 3 subsequent scan_done pulses, then 0.
